// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: FSM encoding,
// store width codes and the memory-mapped I/O region tag.
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int RD_BYTES   = 4;

  localparam logic [1:0]  IO_ADDR_HI = 2'b11;
  localparam logic        TRUE       = 1'b1;
  localparam logic        FALSE      = 1'b0;
  localparam logic [31:0] ZERO       = 32'd0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ_MEM = 3'd1,
    S_READ_IF  = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [3:0] WC_WORD = 4'd0;
  localparam logic [3:0] WC_HALF = 4'd2;
  localparam logic [3:0] WC_BYTE = 4'd3;

  // Unknown width codes fall back to a full word store.
  function automatic logic [2:0] write_len(input logic [3:0] code);
    case (code)
      WC_WORD: return 3'd4;
      WC_HALF: return 3'd2;
      WC_BYTE: return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_assembler.sv
// Byte-lane register: merges incoming read bytes into a little-endian word
// and selects outgoing store bytes from the latched write data.
module mem_ctrl_assembler
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  din,
  input  logic [31:0] wdata,
  input  logic [1:0]  sel_idx,
  output logic [31:0] word_o,
  output logic [7:0]  byte_o
);

  logic [31:0] word_q;
  logic [31:0] word_d;

  // word_o already carries the byte being captured this cycle, so the
  // final byte of a read can be forwarded without waiting an extra edge.
  always_comb begin
    word_d = word_q;
    if (cap_en) word_d[{cap_idx, 3'b000} +: 8] = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) word_q <= ZERO;
    else      word_q <= word_d;
  end

  assign word_o = word_d;
  assign byte_o = wdata[{sel_idx, 3'b000} +: 8];

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating MEM (priority) and IF requests.
// Optional MEMCTRL_IO_STALL_EN holds I/O-region store bytes while the I/O buffer is full.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  mem_r_req_i,
  input  logic                  mem_w_req_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_w_data_i,
  input  logic [3:0]            mem_buffer_pointer_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_r_data_o,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_done_o,
  output logic [31:0]           if_data_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din_i,
  input  logic                  io_buffer_full_i,
  output state_e                dbg_state_o
);

  // Handshake: requests are levels held by the requester until its done
  // pulse; the pulse lasts one cycle, and the DONE state ignores requests so
  // a still-held level is not accepted twice.

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           mem_r_data_q, mem_r_data_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [2:0]            len_q, len_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  mem_done_q, mem_done_d;
  logic                  if_done_q, if_done_d;

  logic                  cap_en;
  logic [1:0]            cap_idx;
  logic [31:0]           asm_word;
  logic [7:0]            asm_byte;
  logic [ADDR_WIDTH-1:0] cur_a;
  logic [ADDR_WIDTH-1:0] next_a;
  logic                  io_full;
  logic                  stall_first, stall_cur, stall_next;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_full = io_buffer_full_i;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full_i;
  assign io_full = FALSE;
`endif

  assign cur_a       = addr_q + ADDR_WIDTH'(cnt_q);
  assign next_a      = cur_a + 32'd1;
  assign stall_first = io_full && (mem_addr_i[17:16] == IO_ADDR_HI);
  assign stall_cur   = io_full && (cur_a[17:16] == IO_ADDR_HI);
  assign stall_next  = io_full && (next_a[17:16] == IO_ADDR_HI);

  mem_ctrl_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (cap_en),
    .cap_idx (cap_idx),
    .din     (ram_din_i),
    .wdata   (wdata_q),
    .sel_idx (cnt_q[1:0] + 2'd1),
    .word_o  (asm_word),
    .byte_o  (asm_byte)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ram_a_d      = ram_a_q;
    wdata_d      = wdata_q;
    mem_r_data_d = mem_r_data_q;
    if_data_d    = if_data_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = ram_wr_q;
    mem_done_d   = mem_done_q;
    if_done_d    = if_done_q;
    cap_en       = FALSE;
    cap_idx      = cnt_q[1:0] - 2'd1;

    if (rdy) begin
      mem_done_d = FALSE;
      if_done_d  = FALSE;
      case (state_q)
        S_IDLE: begin
          ram_a_d    = '0;
          ram_wr_d   = FALSE;
          ram_dout_d = '0;
          cnt_d      = '0;
          if (mem_w_req_i) begin
            state_d    = S_WRITE;
            addr_d     = mem_addr_i;
            wdata_d    = mem_w_data_i;
            len_d      = write_len(mem_buffer_pointer_i);
            ram_a_d    = mem_addr_i;
            ram_dout_d = mem_w_data_i[7:0];
            ram_wr_d   = !stall_first;
          end else if (mem_r_req_i) begin
            state_d = S_READ_MEM;
            addr_d  = mem_addr_i;
            ram_a_d = mem_addr_i;
          end else if (if_req_i) begin
            state_d = S_READ_IF;
            addr_d  = if_addr_i;
            ram_a_d = if_addr_i;
          end
        end
        // cnt_q is the byte index on the address bus; byte cnt_q-1 arrives on ram_din_i.
        S_READ_MEM, S_READ_IF: begin
          cap_en = (cnt_q != 3'd0);
          if (cnt_q == 3'(RD_BYTES)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            if (state_q == S_READ_MEM) begin
              mem_r_data_d = asm_word;
              mem_done_d   = TRUE;
            end else begin
              if_data_d = asm_word;
              if_done_d = TRUE;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            ram_a_d = (cnt_q == 3'(RD_BYTES - 1)) ? '0 : next_a;
          end
        end
        // ram_wr_q low here means the current byte is being held for I/O.
        S_WRITE: begin
          if (!ram_wr_q) begin
            ram_wr_d = !stall_cur;
          end else if (cnt_q + 3'd1 == len_q) begin
            state_d    = S_DONE;
            ram_wr_d   = FALSE;
            ram_a_d    = '0;
            ram_dout_d = '0;
            cnt_d      = '0;
            mem_done_d = TRUE;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            ram_a_d    = next_a;
            ram_dout_d = asm_byte;
            ram_wr_d   = !stall_next;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      ram_a_q      <= '0;
      wdata_q      <= ZERO;
      mem_r_data_q <= ZERO;
      if_data_q    <= ZERO;
      len_q        <= '0;
      cnt_q        <= '0;
      ram_dout_q   <= '0;
      ram_wr_q     <= FALSE;
      mem_done_q   <= FALSE;
      if_done_q    <= FALSE;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ram_a_q      <= ram_a_d;
      wdata_q      <= wdata_d;
      mem_r_data_q <= mem_r_data_d;
      if_data_q    <= if_data_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
      mem_done_q   <= mem_done_d;
      if_done_q    <= if_done_d;
    end
  end

  // The strobe is gated directly so a frozen cycle can never write.
  assign ram_wr_o     = ram_wr_q & rdy;
  assign ram_a_o      = ram_a_q;
  assign ram_dout_o   = ram_dout_q;
  assign mem_done_o   = mem_done_q;
  assign if_done_o    = if_done_q;
  assign mem_r_data_o = mem_r_data_q;
  assign if_data_o    = if_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-serial memory controller between the pipeline and the 8-bit unified RAM bus. Services the MEM stage's load/store requests and the IF stage's instruction-fetch requests. Each request becomes a sequence of single-byte RAM accesses. Returns a one-cycle done pulse with assembled little-endian data; MEM has fixed priority over IF.

Parameters:
ADDR_WIDTH, 32, width of all addresses
RD_BYTES, 4, bytes fetched per read request (loads and fetches); the MEM stage sign/zero-extends
IO_ADDR_HI, 2'b11, value of addr[17:16] marking the memory-mapped I/O region

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
rdy  input  1  global ready; low freezes the block
mem_r_req_i  input  1  MEM-stage load request (level, held until done)
mem_w_req_i  input  1  MEM-stage store request (level, held until done)
mem_addr_i  input  32  MEM-stage byte address
mem_w_data_i  input  32  store data, right-aligned
mem_buffer_pointer_i  input  4  store width code: 0=4 bytes, 2=2 bytes, 3=1 byte
mem_done_o  output  1  one-cycle completion pulse to MEM stage
mem_r_data_o  output  32  assembled load data
if_req_i  input  1  fetch request (level, held until done)
if_addr_i  input  32  fetch address
if_done_o  output  1  one-cycle completion pulse to IF stage
if_data_o  output  32  fetched instruction
ram_a_o  output  32  RAM byte address
ram_dout_o  output  8  RAM write byte
ram_wr_o  output  1  RAM write strobe (1=write)
ram_din_i  input  8  RAM read byte, valid one cycle after its address
io_buffer_full_i  input  1  I/O output buffer full (used only with the optional feature)

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs 0; byte counters 0; data registers 0.
- All outputs registered; RAM read latency is 1 cycle.
- IDLE: if mem_w_req_i, go to WRITE; else if mem_r_req_i, go to READ_MEM; else if if_req_i, go to READ_IF. Latch address, data and length on entry. ram_a_o=0 and ram_wr_o=0 while idle.
- Simultaneous MEM and IF requests: MEM wins; IF waits. An accepted transfer is never preempted.
- READ_x: drive ram_a_o=addr+i for i=0..3 in consecutive cycles. Capture ram_din_i into byte i one cycle later (byte i -> bits [8i+7:8i]). On the edge capturing byte 3, set the done pulse and data output and go to DONE. Request seen in cycle c -> done high in cycle c+6.
- WRITE: n = 4 - buffer_pointer (0->4, 2->2, 3->1; any other code is treated as 4). Drive ram_wr_o=1, ram_a_o=addr+i, ram_dout_o=w_data[8i+7:8i] for i=0..n-1, one per cycle. Next cycle: ram_wr_o=0, done pulse, go to DONE. Request in cycle c -> done in cycle c+n+1.
- DONE: one cycle. Requests are ignored so a still-held request is not re-accepted before the pipeline advances. Then go to IDLE.
- mem_done_o/if_done_o are high exactly one cycle per transfer. mem_r_data_o/if_data_o hold their value until the next read of that port completes. Writes do not change mem_r_data_o.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- rdy low: no state, counter or register changes; ram_wr_o forced 0. The frozen byte is re-issued when rdy returns high.
- Reset mid-transfer: abort immediately, no done pulse. Bytes already written remain in RAM.
- A request withdrawn mid-transfer is still completed, and its done pulse is still issued.

Optional Feature:
MEMCTRL_IO_STALL_EN
- Defined: in WRITE, a byte whose address has addr[17:16]==IO_ADDR_HI is held while io_buffer_full_i=1. During the hold, ram_wr_o=0 and the counter does not advance. It is issued on the first cycle io_buffer_full_i=0, and done is delayed by the stall length.
- Undefined: io_buffer_full_i is ignored; the port remains for interface stability.

Decomposition:
- Shared package/defines: state encoding (IDLE, READ_MEM, READ_IF, WRITE, DONE), width codes 0/2/3, IO_ADDR_HI, True/False/Zero constants.
- One natural sub-module: mem_ctrl_assembler, a byte-lane shift/assemble register (capture byte i into a 32-bit word, byte-select for writes).
- The FSM stays in mem_ctrl.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44 -> ram_a_o 0x100..0x103 in cycles c+1..c+4; mem_r_data_o=0x44332211; mem_done_o high in c+6 only.
- SB, addr 0x20, data 0xDEADBEEF, pointer 3 -> single write of 0xEF at 0x20, ram_wr_o high 1 cycle; done in c+2.
- SW with if_req_i held the same cycle at 0x0 -> write 0x20..0x23 completes first; fetch starts the cycle after DONE; if_done_o fires after mem_done_o.
- rdy low for 3 cycles during byte 1 of a read -> done delayed exactly 3 cycles, data correct, no ram_wr_o activity.
- rst low at cycle c+3 of a 4-byte write -> outputs 0 immediately, no done pulse; only bytes 0..1 written.
- With MEMCTRL_IO_STALL_EN, SB to 0x30000, io_buffer_full_i=1 for 5 cycles -> ram_wr_o stays 0 for 5 cycles, then one write; done 5 cycles late. Without the macro -> no stall.
